// File: rtl/mpc_pkg.sv
// Shared Q16.16 types, constants and saturating arithmetic helpers for the MPC/IncCond MPPT controller.
package mpc_pkg;

  typedef logic signed [31:0] q16_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_S1,
    ST_S2,
    ST_S3
  } state_t;

  localparam q16_t Q_ONE   = 32'sh0001_0000;
  localparam q16_t D_RESET = 32'sh0000_8000;
  localparam q16_t Q_MAX   = 32'sh7FFF_FFFF;
  localparam q16_t Q_MIN   = 32'sh8000_0000;

  localparam q16_t STEP_DEF  = 32'sh0000_028F;
  localparam q16_t D_MIN_DEF = 32'sh0000_0CCD;
  localparam q16_t D_MAX_DEF = 32'sh0000_F333;
  localparam q16_t TOL_DEF   = 32'sh0000_0100;

  // A 33-bit result overflowed exactly when its top two bits disagree.
  function automatic q16_t sat33(input logic signed [32:0] s);
    if (s[32] != s[31]) begin
      return s[32] ? Q_MIN : Q_MAX;
    end
    return s[31:0];
  endfunction

  function automatic q16_t q_add(input q16_t a, input q16_t b);
    return sat33({a[31], a} + {b[31], b});
  endfunction

  function automatic q16_t q_sub(input q16_t a, input q16_t b);
    return sat33({a[31], a} - {b[31], b});
  endfunction

  function automatic q16_t q_abs(input q16_t a);
    return a[31] ? q_sub(32'sd0, a) : a;
  endfunction

endpackage

// File: rtl/q16_mul.sv
// Combinational saturating signed Q16.16 multiply: 64-bit product, bits [47:16] kept.
module q16_mul
  import mpc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] full;
  logic               overflow;

  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign full  = a_ext * b_ext;

  // Bits above the kept window must all be copies of the sign for the result to fit.
  assign overflow = (full[63:47] != {17{full[63]}});
  assign p        = overflow ? (full[63] ? Q_MIN : Q_MAX) : full[47:16];

endmodule

// File: rtl/mpc_inc_cond.sv
// Model-predictive MPPT duty controller with an optional incremental-conductance hold.
// Optional feature macro: MPC_INCCOND_HOLD_EN (hold duty when the IncCond residual is within TOL).
module mpc_inc_cond
  import mpc_pkg::*;
#(
  parameter q16_t STEP  = STEP_DEF,
  parameter q16_t D_MIN = D_MIN_DEF,
  parameter q16_t D_MAX = D_MAX_DEF,
  parameter q16_t TOL   = TOL_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_Vpv,
  input  logic [31:0] i_Ipv,
  input  logic [31:0] i_Vout,
  input  logic [31:0] i_Ipv_plus,
  input  logic [31:0] i_Ipv_minus,
  input  logic        i_calc_DV,
  output logic [31:0] o_DC_control,
  output logic        o_DV
);

  state_t state;
  state_t state_next;

  q16_t d;
  q16_t d_next;
  q16_t vout_r;
  q16_t ipp_r;
  q16_t ipm_r;
  q16_t dp_r;
  q16_t dm_r;
  q16_t vp_r;
  q16_t vm_r;
  q16_t pp_r;
  q16_t pm_r;

  q16_t dp_c;
  q16_t dm_c;
  q16_t one_m_dp;
  q16_t one_m_dm;
  q16_t vp_c;
  q16_t vm_c;
  q16_t pp_c;
  q16_t pm_c;
  logic hold_c;

  assign o_DC_control = d;

  assign dp_c     = q_add(d, STEP);
  assign dm_c     = q_sub(d, STEP);
  assign one_m_dp = q_sub(Q_ONE, dp_c);
  assign one_m_dm = q_sub(Q_ONE, dm_c);

  q16_mul u_mul_vp (.a(vout_r), .b(one_m_dp), .p(vp_c));
  q16_mul u_mul_vm (.a(vout_r), .b(one_m_dm), .p(vm_c));
  q16_mul u_mul_pp (.a(vp_r),   .b(ipp_r),    .p(pp_c));
  q16_mul u_mul_pm (.a(vm_r),   .b(ipm_r),    .p(pm_c));

`ifdef MPC_INCCOND_HOLD_EN
  q16_t vpv_r;
  q16_t ipv_r;
  q16_t prev_v;
  q16_t prev_i;
  q16_t dv_r;
  q16_t di_r;
  q16_t g_r;
  q16_t gv_c;
  q16_t gi_c;
  q16_t g_c;
  logic first_done;

  // g = dI*V + I*dV is zero at the maximum power point.
  q16_mul u_mul_gv (.a(di_r),  .b(vpv_r), .p(gv_c));
  q16_mul u_mul_gi (.a(ipv_r), .b(dv_r),  .p(gi_c));

  assign g_c    = q_add(gv_c, gi_c);
  assign hold_c = first_done && (q_abs(g_r) <= TOL);
`else
  logic unused_pv;

  assign hold_c    = 1'b0;
  assign unused_pv = ^{i_Vpv, i_Ipv};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // New requests are only taken from idle, so pulses during a busy pipeline are dropped.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (i_calc_DV) state_next = ST_S1;
      ST_S1:   state_next = ST_S2;
      ST_S2:   state_next = ST_S3;
      ST_S3:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    d_next = d;
    if (hold_c) begin
      d_next = d;
    end else if (pp_r > pm_r) begin
      d_next = (dp_r > D_MAX) ? D_MAX : dp_r;
    end else if (pp_r < pm_r) begin
      d_next = (dm_r < D_MIN) ? D_MIN : dm_r;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d      <= D_RESET;
      o_DV   <= 1'b0;
      vout_r <= '0;
      ipp_r  <= '0;
      ipm_r  <= '0;
      dp_r   <= '0;
      dm_r   <= '0;
      vp_r   <= '0;
      vm_r   <= '0;
      pp_r   <= '0;
      pm_r   <= '0;
`ifdef MPC_INCCOND_HOLD_EN
      vpv_r      <= '0;
      ipv_r      <= '0;
      prev_v     <= '0;
      prev_i     <= '0;
      dv_r       <= '0;
      di_r       <= '0;
      g_r        <= '0;
      first_done <= 1'b0;
`endif
    end else begin
      o_DV <= (state == ST_S3);
      case (state)
        ST_IDLE: begin
          if (i_calc_DV) begin
            vout_r <= i_Vout;
            ipp_r  <= i_Ipv_plus;
            ipm_r  <= i_Ipv_minus;
`ifdef MPC_INCCOND_HOLD_EN
            vpv_r  <= i_Vpv;
            ipv_r  <= i_Ipv;
`endif
          end
        end
        ST_S1: begin
          dp_r <= dp_c;
          dm_r <= dm_c;
          vp_r <= vp_c;
          vm_r <= vm_c;
`ifdef MPC_INCCOND_HOLD_EN
          dv_r <= q_sub(vpv_r, prev_v);
          di_r <= q_sub(ipv_r, prev_i);
`endif
        end
        ST_S2: begin
          pp_r <= pp_c;
          pm_r <= pm_c;
`ifdef MPC_INCCOND_HOLD_EN
          g_r  <= g_c;
`endif
        end
        ST_S3: begin
          d <= d_next;
`ifdef MPC_INCCOND_HOLD_EN
          prev_v     <= vpv_r;
          prev_i     <= ipv_r;
          first_done <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_inc_cond.sv
// Directed, table-driven bench for mpc_inc_cond; expectations are hand-computed Q16.16 duty values.
module tb_mpc_inc_cond;

  typedef struct {
    logic [31:0] vpv;
    logic [31:0] ipv;
    logic [31:0] vout;
    logic [31:0] ipp;
    logic [31:0] ipm;
    logic [31:0] exp_dc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] vpv;
  logic [31:0] ipv;
  logic [31:0] vout;
  logic [31:0] ipp;
  logic [31:0] ipm;
  logic        calc;
  logic [31:0] dc;
  logic        dv;

  int checks = 0;
  int errors = 0;

  vec_t vecs[6];

  mpc_inc_cond dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_Vpv        (vpv),
    .i_Ipv        (ipv),
    .i_Vout       (vout),
    .i_Ipv_plus   (ipp),
    .i_Ipv_minus  (ipm),
    .i_calc_DV    (calc),
    .o_DC_control (dc),
    .o_DV         (dv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst  = 1'b1;
    calc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Caller sits at a negedge; leaves at the next negedge (one cycle after the request).
  task automatic startOp(input vec_t v);
    vpv  = v.vpv;
    ipv  = v.ipv;
    vout = v.vout;
    ipp  = v.ipp;
    ipm  = v.ipm;
    calc = 1'b1;
    @(negedge clk);
    calc = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int start_n);
    int n;
    n = start_n;
    while (dv !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd4);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    startOp(v);
    waitDone(tag, 1);
    @(negedge clk);
    checkOutput({tag, "_pulse_width"}, {31'b0, dv}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, c, d, e, f);
    vec_t v;
    v.vpv = a; v.ipv = b; v.vout = c; v.ipp = d; v.ipm = e; v.exp_dc = f;
    return v;
  endfunction

  initial begin
    vec_t v;
    vec_t v0;
    vec_t vb;
    logic [31:0] hold_exp;
    int cnt;

    vpv = '0; ipv = '0; vout = '0; ipp = '0; ipm = '0; calc = 1'b0; rst = 1'b0;

    vecs[0] = mk(32'h0023_0000, 32'h0004_8000, 32'h0050_0000, 32'h0005_0000, 32'h0004_0000, 32'h0000_828F);
    vecs[1] = mk(32'h001E_0000, 32'h0005_0000, 32'h0050_0000, 32'h0003_0000, 32'h0005_0000, 32'h0000_8000);
    vecs[2] = mk(32'h0028_0000, 32'h0003_0000, 32'h0050_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_8000);
    vecs[3] = mk(32'h0020_0000, 32'h0005_0000, 32'h0050_0000, 32'h0006_0000, 32'h0002_0000, 32'h0000_828F);
    vecs[4] = mk(32'h0024_0000, 32'h0004_0000, 32'h0050_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_8000);
    vecs[5] = mk(32'h0014_0000, 32'h0002_0000, 32'h7FFF_0000, 32'h0005_0000, 32'h000A_0000, 32'h0000_8000);
    v0 = vecs[0];

    doReset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_dv", {31'b0, dv}, 32'd0);
      checkOutput("idle_dc", dc, 32'h0000_8000);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_dc", i), dc, vecs[i].exp_dc);
    end

    for (int i = 0; i < 50; i++) begin
      v = mk((i % 2) ? 32'h000F_0000 : 32'h000A_0000, 32'h0002_0000, 32'h0050_0000,
             32'h0005_0000, 32'h0000_0000, 32'h0);
      applyStimulus(v, "up");
      if (i == 44) checkOutput("up_before_clamp", dc, 32'h0000_F323);
      if (i == 49) checkOutput("up_clamp_dmax", dc, 32'h0000_F333);
    end

    for (int i = 0; i < 100; i++) begin
      v = mk((i % 2) ? 32'h000F_0000 : 32'h000A_0000, 32'h0002_0000, 32'h0050_0000,
             32'h0000_0000, 32'h0005_0000, 32'h0);
      applyStimulus(v, "down");
      if (i == 89) checkOutput("down_before_clamp", dc, 32'h0000_0CED);
      if (i == 99) checkOutput("down_clamp_dmin", dc, 32'h0000_0CCD);
    end

    // Back-to-back: a request in the o_DV cycle starts a new operation.
    doReset();
    @(negedge clk);
    startOp(v0);
    waitDone("b2b_first", 1);
    checkOutput("b2b_first_dc", dc, 32'h0000_828F);
    startOp(vecs[1]);
    waitDone("b2b_second", 1);
    checkOutput("b2b_second_dc", dc, 32'h0000_8000);

    // A request while busy is dropped and does not alter the running result.
    doReset();
    vb = mk(32'h0011_0000, 32'h0001_0000, 32'h0050_0000, 32'h0000_0000, 32'h0005_0000, 32'h0);
    @(negedge clk);
    startOp(v0);
    @(negedge clk);
    startOp(vb);
    waitDone("busy", 3);
    checkOutput("busy_dc", dc, 32'h0000_828F);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dv === 1'b1) cnt++;
    end
    checkOutput("busy_extra_dv", 32'(cnt), 32'd0);

    // Reset during S2 aborts the operation with no o_DV.
    @(negedge clk);
    startOp(v0);
    @(negedge clk);
    rst  = 1'b1;
    calc = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    calc = 1'b0;
    cnt  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dv === 1'b1) cnt++;
    end
    checkOutput("rst_mid_dv", 32'(cnt), 32'd0);
    checkOutput("rst_mid_dc", dc, 32'h0000_8000);
    applyStimulus(v0, "after_rst");
    checkOutput("after_rst_dc", dc, 32'h0000_828F);

    // Same operating point twice: g = 0 on the second decision.
    doReset();
    applyStimulus(v0, "hold_first");
    checkOutput("hold_first_dc", dc, 32'h0000_828F);
`ifdef MPC_INCCOND_HOLD_EN
    hold_exp = 32'h0000_828F;
`else
    hold_exp = 32'h0000_851E;
`endif
    applyStimulus(v0, "hold_second");
    checkOutput("hold_second_dc", dc, hold_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
